collatz_seq_monitor: RTL and testbench

Sequence reader for the Collatz datapath. Samples the value stream produced by the main Collatz register each time it updates, checks that every value is the correct successor of the previous one, and reports stopping time, peak value and termination or error status. Sits beside the main register on the same clock. Its counters feed the 4-digit display path as an alternate readout.

---
 rtl/collatz_pkg.sv | 21 ++
 rtl/collatz_next.sv | 15 +
 rtl/collatz_seq_monitor.sv | 122 ++++++++++++
 tb/tb_collatz_seq_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/collatz_pkg.sv
// Shared widths, monitor state encoding and error codes for the Collatz datapath.
package collatz_pkg;

  localparam int COLLATZ_VAL_W  = 13;
  localparam int COLLATZ_STEP_W = 9;

  typedef enum logic [1:0] {
    MON_IDLE  = 2'd0,
    MON_TRACK = 2'd1,
    MON_DONE  = 2'd2,
    MON_ERROR = 2'd3
  } mon_state_t;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ZERO_START = 2'd1,
    ERR_OVERFLOW   = 2'd2,
    ERR_MISMATCH   = 2'd3
  } err_code_t;

endpackage

// File: rtl/collatz_next.sv
// Combinational Collatz successor; two extra result bits so 3n+1 never wraps.
module collatz_next #(
  parameter int VAL_W = 13
) (
  input  logic [VAL_W-1:0] value_i,
  output logic [VAL_W+1:0] next_o
);

  logic [VAL_W+1:0] ext;

  assign ext    = {2'b00, value_i};
  assign next_o = value_i[0] ? (ext + (ext << 1) + {{(VAL_W+1){1'b0}}, 1'b1})
                             : (ext >> 1);

endmodule

// File: rtl/collatz_seq_monitor.sv
// Collatz sequence monitor: tracks steps/peak and flags bad sequences.
// Successor comparison is built only when COLLATZ_MON_CHECK_EN is defined.
//
//   state | meaning
//   IDLE  | waiting for a start sample
//   TRACK | following a sequence, checking each successor
//   DONE  | value 1 reached, outputs held
//   ERROR | zero start, overflow or mismatch, outputs held
module collatz_seq_monitor
  import collatz_pkg::*;
#(
  parameter int VAL_W  = COLLATZ_VAL_W,
  parameter int STEP_W = COLLATZ_STEP_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              in_start,
  input  logic [VAL_W-1:0]  in_value,
  input  logic              clear,
  output logic [STEP_W-1:0] steps,
  output logic [VAL_W-1:0]  peak,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [1:0] S_IDLE  = MON_IDLE;
  localparam logic [1:0] S_TRACK = MON_TRACK;
  localparam logic [1:0] S_DONE  = MON_DONE;
  localparam logic [1:0] S_ERROR = MON_ERROR;

  logic [1:0]        state_q, state_d;
  logic [VAL_W-1:0]  prev_q, prev_d;
  logic [VAL_W-1:0]  peak_q, peak_d;
  logic [STEP_W-1:0] steps_q, steps_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [VAL_W+1:0]  expected;
  logic              overflow;
  logic              mismatch;

  collatz_next #(.VAL_W(VAL_W)) u_next (
    .value_i (prev_q),
    .next_o  (expected)
  );

  assign overflow = |expected[VAL_W+1:VAL_W];

`ifdef COLLATZ_MON_CHECK_EN
  assign mismatch = (in_value != expected[VAL_W-1:0]);
`else
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    peak_d     = peak_q;
    steps_d    = steps_q;
    err_code_d = err_code_q;
    if (clear) begin
      state_d    = S_IDLE;
      prev_d     = '0;
      peak_d     = '0;
      steps_d    = '0;
      err_code_d = ERR_NONE;
    end else if (in_valid && in_start) begin
      prev_d     = in_value;
      peak_d     = in_value;
      steps_d    = '0;
      err_code_d = ERR_NONE;
      if (in_value == '0) begin
        state_d    = S_ERROR;
        err_code_d = ERR_ZERO_START;
      end else if (in_value == VAL_W'(1)) begin
        state_d = S_DONE;
      end else begin
        state_d = S_TRACK;
      end
    end else if (in_valid && state_q == S_TRACK) begin
      // Overflow is judged on prev alone, so the offending sample is dropped
      if (overflow) begin
        state_d    = S_ERROR;
        err_code_d = ERR_OVERFLOW;
      end else if (mismatch) begin
        state_d    = S_ERROR;
        err_code_d = ERR_MISMATCH;
      end else begin
        prev_d  = in_value;
        steps_d = (&steps_q) ? steps_q : steps_q + 1'b1;
        if (in_value > peak_q) peak_d = in_value;
        if (in_value == VAL_W'(1)) state_d = S_DONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      prev_q     <= '0;
      peak_q     <= '0;
      steps_q    <= '0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      peak_q     <= peak_d;
      steps_q    <= steps_d;
      err_code_q <= err_code_d;
    end
  end

  assign steps    = steps_q;
  assign peak     = peak_q;
  assign err_code = err_code_q;
  assign busy     = (state_q == S_TRACK);
  assign done     = (state_q == S_DONE);
  assign err      = (state_q == S_ERROR);

endmodule

// File: tb/tb_collatz_seq_monitor.sv
// Directed bench for collatz_seq_monitor; expectations follow COLLATZ_MON_CHECK_EN.
module tb_collatz_seq_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_start;
  logic [12:0] in_value;
  logic        clear;
  logic [8:0]  steps;
  logic [12:0] peak;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;

  int n_total = 0;
  int n_pass  = 0;

  collatz_seq_monitor dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_start (in_start),
    .in_value (in_value),
    .clear    (clear),
    .steps    (steps),
    .peak     (peak),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic put(input logic s, input logic [12:0] v);
    @(negedge clk);
    in_valid = 1'b1;
    in_start = s;
    in_value = v;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    clear    = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_start = 1'b0; in_value = '0; clear = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({busy, done, err, err_code, steps, peak} !== 27'd0)
      $display("FAIL reset_state: busy=%0b done=%0b err=%0b code=%0d steps=%0d peak=%0d, required all 0",
               busy, done, err, err_code, steps, peak);
    else n_pass++;
    reset = 1'b0;
    put(1'b0, 13'd5);
    idle();
    n_total++;
    if ({busy, steps, peak} !== 23'd0)
      $display("FAIL idle_ignore: busy=%0b steps=%0d peak=%0d, required 0 0 0", busy, steps, peak);
    else n_pass++;
  endtask

  task automatic test_six();
    int seq [8] = '{3, 10, 5, 16, 8, 4, 2, 1};
    put(1'b1, 13'd6);
    for (int i = 0; i < 8; i++) put(1'b0, 13'(seq[i]));
    idle();
    n_total++;
    if ({done, err, busy, steps, peak} !== {1'b1, 1'b0, 1'b0, 9'd8, 13'd16})
      $display("FAIL six_seq: done=%0b err=%0b busy=%0b steps=%0d peak=%0d, required 1 0 0 8 16",
               done, err, busy, steps, peak);
    else n_pass++;
    put(1'b0, 13'd4);
    idle();
    n_total++;
    if ({done, steps, peak} !== {1'b1, 9'd8, 13'd16})
      $display("FAIL done_hold: done=%0b steps=%0d peak=%0d, required 1 8 16", done, steps, peak);
    else n_pass++;
  endtask

  task automatic test_seven();
    int n = 7;
    put(1'b1, 13'd7);
    while (n != 1) begin
      n = (n % 2 == 1) ? 3 * n + 1 : n / 2;
      put(1'b0, 13'(n));
    end
    idle();
    n_total++;
    if ({done, err, steps, peak} !== {1'b1, 1'b0, 9'd16, 13'd52})
      $display("FAIL seven_seq: done=%0b err=%0b steps=%0d peak=%0d, required 1 0 16 52",
               done, err, steps, peak);
    else n_pass++;
  endtask

  task automatic test_mismatch();
    put(1'b1, 13'd6);
    put(1'b0, 13'd3);
    put(1'b0, 13'd11);
    idle();
    n_total++;
`ifdef COLLATZ_MON_CHECK_EN
    if ({err, err_code, busy, steps, peak} !== {1'b1, 2'd3, 1'b0, 9'd1, 13'd6})
      $display("FAIL mismatch: err=%0b code=%0d busy=%0b steps=%0d peak=%0d, required 1 3 0 1 6",
               err, err_code, busy, steps, peak);
    else n_pass++;
`else
    if ({err, err_code, busy, steps, peak} !== {1'b0, 2'd0, 1'b1, 9'd2, 13'd11})
      $display("FAIL mismatch: err=%0b code=%0d busy=%0b steps=%0d peak=%0d, required 0 0 1 2 11",
               err, err_code, busy, steps, peak);
    else n_pass++;
`endif
    put(1'b1, 13'd5);
    put(1'b0, 13'd5);
    idle();
    n_total++;
`ifdef COLLATZ_MON_CHECK_EN
    if ({err, err_code, steps, peak} !== {1'b1, 2'd3, 9'd0, 13'd5})
      $display("FAIL repeat_sample: err=%0b code=%0d steps=%0d peak=%0d, required 1 3 0 5",
               err, err_code, steps, peak);
    else n_pass++;
`else
    if ({err, busy, steps, peak} !== {1'b0, 1'b1, 9'd1, 13'd5})
      $display("FAIL repeat_sample: err=%0b busy=%0b steps=%0d peak=%0d, required 0 1 1 5",
               err, busy, steps, peak);
    else n_pass++;
`endif
  endtask

  task automatic test_start_precedence();
    put(1'b1, 13'd7);
    put(1'b0, 13'd22);
    put(1'b1, 13'd9);
    idle();
    n_total++;
    if ({busy, err, err_code, steps, peak} !== {1'b1, 1'b0, 2'd0, 9'd0, 13'd9})
      $display("FAIL start_precedence: busy=%0b err=%0b code=%0d steps=%0d peak=%0d, required 1 0 0 0 9",
               busy, err, err_code, steps, peak);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int n = 27;
    put(1'b1, 13'd27);
    while (n != 3077) begin
      n = (n % 2 == 1) ? 3 * n + 1 : n / 2;
      put(1'b0, 13'(n));
    end
    idle();
    n_total++;
    if ({busy, err, steps, peak} !== {1'b1, 1'b0, 9'd76, 13'd7288})
      $display("FAIL pre_overflow: busy=%0b err=%0b steps=%0d peak=%0d, required 1 0 76 7288",
               busy, err, steps, peak);
    else n_pass++;
    put(1'b0, 13'd1040);
    idle();
    n_total++;
    if ({err, err_code, busy, steps, peak} !== {1'b1, 2'd2, 1'b0, 9'd76, 13'd7288})
      $display("FAIL overflow: err=%0b code=%0d busy=%0b steps=%0d peak=%0d, required 1 2 0 76 7288",
               err, err_code, busy, steps, peak);
    else n_pass++;
  endtask

  task automatic test_zero_one();
    put(1'b1, 13'd0);
    idle();
    n_total++;
    if ({err, err_code, done, busy, steps, peak} !== {1'b1, 2'd1, 1'b0, 1'b0, 9'd0, 13'd0})
      $display("FAIL zero_start: err=%0b code=%0d done=%0b busy=%0b steps=%0d peak=%0d, required 1 1 0 0 0 0",
               err, err_code, done, busy, steps, peak);
    else n_pass++;
    put(1'b0, 13'd5);
    idle();
    n_total++;
    if ({err, err_code, peak} !== {1'b1, 2'd1, 13'd0})
      $display("FAIL error_hold: err=%0b code=%0d peak=%0d, required 1 1 0", err, err_code, peak);
    else n_pass++;
    put(1'b1, 13'd1);
    put(1'b0, 13'd4);
    idle();
    n_total++;
    if ({done, err, err_code, steps, peak} !== {1'b1, 1'b0, 2'd0, 9'd0, 13'd1})
      $display("FAIL one_start: done=%0b err=%0b code=%0d steps=%0d peak=%0d, required 1 0 0 0 1",
               done, err, err_code, steps, peak);
    else n_pass++;
  endtask

  task automatic test_saturation();
`ifndef COLLATZ_MON_CHECK_EN
    put(1'b1, 13'd2);
    for (int i = 0; i < 515; i++) put(1'b0, 13'd2);
    idle();
    n_total++;
    if ({busy, steps, peak} !== {1'b1, 9'd511, 13'd2})
      $display("FAIL steps_saturate: busy=%0b steps=%0d peak=%0d, required 1 511 2", busy, steps, peak);
    else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int seq [4] = '{22, 11, 34, 17};
    put(1'b1, 13'd7);
    for (int i = 0; i < 4; i++) put(1'b0, 13'(seq[i]));
    idle();
    n_total++;
    if ({busy, steps, peak} !== {1'b1, 9'd4, 13'd34})
      $display("FAIL mid_track: busy=%0b steps=%0d peak=%0d, required 1 4 34", busy, steps, peak);
    else n_pass++;
    #2 reset = 1'b1;
    #1;
    n_total++;
    if ({busy, done, err, err_code, steps, peak} !== 27'd0)
      $display("FAIL async_reset: busy=%0b done=%0b err=%0b code=%0d steps=%0d peak=%0d, required all 0",
               busy, done, err, err_code, steps, peak);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    put(1'b1, 13'd6);
    put(1'b0, 13'd3);
    idle();
    n_total++;
    if ({busy, err, steps, peak} !== {1'b1, 1'b0, 9'd1, 13'd6})
      $display("FAIL after_reset: busy=%0b err=%0b steps=%0d peak=%0d, required 1 0 1 6",
               busy, err, steps, peak);
    else n_pass++;
  endtask

  task automatic test_clear();
    @(negedge clk);
    in_valid = 1'b1; in_start = 1'b1; in_value = 13'd7; clear = 1'b1;
    idle();
    n_total++;
    if ({busy, done, err, err_code, steps, peak} !== 27'd0)
      $display("FAIL clear_wins: busy=%0b done=%0b err=%0b code=%0d steps=%0d peak=%0d, required all 0",
               busy, done, err, err_code, steps, peak);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_six();
    test_seven();
    test_mismatch();
    test_start_precedence();
    test_overflow();
    test_zero_one();
    test_saturation();
    test_reset_mid();
    test_clear();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
